// File: rtl/interleave_pkg.sv
// Shared constants and lane-index wrap helper for the interleaved FIFO lanes.
package interleave_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_NUM_LANES  = 4;

    // Explicit compare so non-power-of-two lane counts wrap correctly.
    function automatic int unsigned next_lane(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/skid_reg.sv
// Two-entry registered valid/ready buffer; in_ready depends only on local state.
module skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_push;
    logic             w_pop;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign w_push    = in_valid && !r_skid_valid;
    assign w_pop     = r_main_valid && out_ready;

    // Skid only fills when main is stalled; it drains back into main on the next pop.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_skid_valid) begin
            if (w_push) begin
                if (!r_main_valid || out_ready) begin
                    r_main_data  <= in_data;
                    r_main_valid <= 1'b1;
                end else begin
                    r_skid_data  <= in_data;
                    r_skid_valid <= 1'b1;
                end
            end else if (w_pop) begin
                r_main_valid <= 1'b0;
            end
        end else if (w_pop) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_lane_merger.sv
// Strict round-robin merge of interleaved lane FIFO outputs into one ordered, registered stream.
module rr_lane_merger
    import interleave_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter  int unsigned NUM_LANES    = DEFAULT_NUM_LANES,
    localparam int unsigned LB_NUM_LANES = $clog2(NUM_LANES)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clear,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
    input  logic [NUM_LANES-1:0]            lane_valid,
    output logic [NUM_LANES-1:0]            lane_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [LB_NUM_LANES-1:0]         out_lane,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LB_NUM_LANES-1:0]         rd_ptr
);

    localparam int unsigned PAYLOAD_W = LB_NUM_LANES + DATA_WIDTH;

    logic [LB_NUM_LANES-1:0] r_rd_ptr;
    logic [DATA_WIDTH-1:0]   w_lane_word;
    logic                    w_lane_valid;
    logic                    w_in_ready;
    logic                    w_accept;
    logic [PAYLOAD_W-1:0]    w_out_payload;

    // Lane mux and one-hot ready for the lane at rd_ptr.
    always_comb begin
        w_lane_word  = '0;
        w_lane_valid = 1'b0;
        lane_ready   = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (LB_NUM_LANES'(i) == r_rd_ptr) begin
                w_lane_word   = lane_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_lane_valid  = lane_valid[i];
                lane_ready[i] = w_in_ready;
            end
        end
    end

    assign w_accept = w_lane_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            r_rd_ptr <= '0;
        end else if (w_accept) begin
            r_rd_ptr <= LB_NUM_LANES'(next_lane(32'(r_rd_ptr), NUM_LANES));
        end
    end

    skid_reg #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .in_valid (w_lane_valid),
        .in_ready (w_in_ready),
        .in_data  ({r_rd_ptr, w_lane_word}),
        .out_valid(out_valid),
        .out_data (w_out_payload),
        .out_ready(out_ready)
    );

    assign out_lane = w_out_payload[PAYLOAD_W-1 -: LB_NUM_LANES];
    assign out_data = w_out_payload[DATA_WIDTH-1:0];
    assign rd_ptr   = r_rd_ptr;

endmodule

// File: tb/tb_rr_lane_merger.sv
// Directed checks of rr_lane_merger: streaming, stall, backpressure, clear, 3-lane wrap.
module tb_rr_lane_merger;

    logic        clk;
    int          n_cmp;
    int          n_err;

    // 4-lane instance
    logic        rstn, clear, out_ready;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid, lane_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane, rd_ptr;
    logic        out_valid;

    // 3-lane instance
    logic        b_rstn, b_clear, b_out_ready;
    logic [23:0] b_lane_data;
    logic [2:0]  b_lane_valid, b_lane_ready;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_lane, b_rd_ptr;
    logic        b_out_valid;

    rr_lane_merger #(.DATA_WIDTH(8), .NUM_LANES(4)) u_dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .lane_data(lane_data), .lane_valid(lane_valid), .lane_ready(lane_ready),
        .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready), .rd_ptr(rd_ptr)
    );

    rr_lane_merger #(.DATA_WIDTH(8), .NUM_LANES(3)) u_dut3 (
        .clk(clk), .rstn(b_rstn), .clear(b_clear),
        .lane_data(b_lane_data), .lane_valid(b_lane_valid), .lane_ready(b_lane_ready),
        .out_data(b_out_data), .out_lane(b_out_lane), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .rd_ptr(b_rd_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0; clear = 1'b0; out_ready = 1'b0;
        lane_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        lane_valid = 4'b0000;
        b_rstn = 1'b0; b_clear = 1'b0; b_out_ready = 1'b1;
        b_lane_data  = {8'h22, 8'h21, 8'h20};
        b_lane_valid = 3'b000;

        // Reset state
        tick(); tick();
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_data",   32'(out_data),   32'd0);
        chk("rst_out_lane",   32'(out_lane),   32'd0);
        chk("rst_lane_ready", 32'(lane_ready), 32'b0001);
        chk("rst_rd_ptr",     32'(rd_ptr),     32'd0);

        // Streaming at one word per cycle, in lane order
        rstn = 1'b1; lane_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data",  32'(out_data),  32'h10 + 32'(k % 4));
            chk("stream_lane",  32'(out_lane),  32'(k % 4));
        end
        chk("stream_rd_ptr", 32'(rd_ptr), 32'd2);

        // Lane 2 not valid: merger stalls, no skipping to lane 3
        lane_valid = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_valid",  32'(out_valid), 32'd0);
            chk("stall_rd_ptr", 32'(rd_ptr),    32'd2);
        end
        lane_valid = 4'b1111;
        tick();
        chk("stall_resume_data", 32'(out_data), 32'h12);
        chk("stall_resume_lane", 32'(out_lane), 32'd2);
        tick();
        chk("stall_next_data", 32'(out_data), 32'h13);
        chk("stall_next_lane", 32'(out_lane), 32'd3);

        // Backpressure: one word lands in skid, lane_ready drops, output holds
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_valid",      32'(out_valid),  32'd1);
            chk("bp_data_held",  32'(out_data),   32'h13);
            chk("bp_lane_ready", 32'(lane_ready), 32'b0000);
            chk("bp_rd_ptr",     32'(rd_ptr),     32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_drain_data",  32'(out_data),   32'h10);
        chk("bp_drain_lane",  32'(out_lane),   32'd0);
        chk("bp_drain_ready", 32'(lane_ready), 32'b0010);
        // Simultaneous pop and accept: no bubble, skid stays empty
        tick();
        chk("popacc_data",  32'(out_data),   32'h11);
        chk("popacc_valid", 32'(out_valid),  32'd1);
        chk("popacc_ready", 32'(lane_ready), 32'b0100);
        tick();
        chk("popacc2_data", 32'(out_data), 32'h12);

        // Fill main and skid, then clear
        out_ready = 1'b0;
        tick();
        chk("pre_clr_ready", 32'(lane_ready), 32'b0000);
        chk("pre_clr_data",  32'(out_data),   32'h12);
        clear = 1'b1;
        tick();
        chk("clr_valid",      32'(out_valid),  32'd0);
        chk("clr_rd_ptr",     32'(rd_ptr),     32'd0);
        chk("clr_lane_ready", 32'(lane_ready), 32'b0001);
        chk("clr_data",       32'(out_data),   32'd0);
        // Lane 0 handshake during a clear cycle is dropped
        out_ready = 1'b1;
        tick();
        chk("clr_hs_valid",  32'(out_valid), 32'd0);
        chk("clr_hs_rd_ptr", 32'(rd_ptr),    32'd0);
        clear = 1'b0;
        tick();
        chk("post_clr_data", 32'(out_data), 32'h10);
        chk("post_clr_lane", 32'(out_lane), 32'd0);

        // 3-lane wrap: rd_ptr 0,1,2,0,... never 3
        b_rstn = 1'b1;
        chk("wrap_rd_ptr0", 32'(b_rd_ptr), 32'd0);
        b_lane_valid = 3'b111;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("wrap_rd_ptr",   32'(b_rd_ptr),   32'((k + 1) % 3));
            chk("wrap_out_lane", 32'(b_out_lane), 32'(k % 3));
            chk("wrap_out_data", 32'(b_out_data), 32'h20 + 32'(k % 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
